// File: rtl/muxn_cxu.sv
`default_nettype none
// ============================================================================
// Module   : muxn_cxu
// Purpose  : N-way in-order CFU-L2 request/response mux with an order queue.
// Revision : 1.0
// ============================================================================
module muxn_cxu #(
  parameter int N_CFUS       = 4,
  parameter int CFU_ID_W     = 4,
  parameter int FUNC_ID_W    = 10,
  parameter int DATA_W       = 32,
  parameter int MAX_INFLIGHT = 8,
  parameter int CFU_STATUS_W = 3,
  parameter logic [CFU_STATUS_W-1:0] CFU_ERROR_CFU = CFU_STATUS_W'(1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic [CFU_ID_W-1:0]            i_req_cfu,
  input  logic [FUNC_ID_W-1:0]           i_req_func,
  input  logic [DATA_W-1:0]              i_req_data0,
  input  logic [DATA_W-1:0]              i_req_data1,
  output logic                           o_resp_valid,
  input  logic                           i_resp_ready,
  output logic [CFU_STATUS_W-1:0]        o_resp_status,
  output logic [DATA_W-1:0]              o_resp_data,
  output logic [N_CFUS-1:0]              o_t_req_valid,
  input  logic [N_CFUS-1:0]              i_t_req_ready,
  output logic [FUNC_ID_W-1:0]           o_t_req_func,
  output logic [DATA_W-1:0]              o_t_req_data0,
  output logic [DATA_W-1:0]              o_t_req_data1,
  input  logic [N_CFUS-1:0]              i_t_resp_valid,
  output logic [N_CFUS-1:0]              o_t_resp_ready,
  input  logic [N_CFUS*CFU_STATUS_W-1:0] i_t_resp_status,
  input  logic [N_CFUS*DATA_W-1:0]       i_t_resp_data
);

  localparam int c_tag_w = $clog2(N_CFUS + 1);
  localparam int c_ptr_w = $clog2(MAX_INFLIGHT);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_tag_w-1:0]  c_tag_err = c_tag_w'(N_CFUS);
  localparam logic [c_cnt_w-1:0]  c_depth   = c_cnt_w'(MAX_INFLIGHT);
  localparam logic [CFU_ID_W:0]   c_n_cfus  = (CFU_ID_W + 1)'(N_CFUS);

  logic [c_tag_w-1:0] r_tags [MAX_INFLIGHT];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic               w_full;
  logic               w_empty;
  logic               w_hit;
  logic [N_CFUS-1:0]  w_sel;
  logic               w_tgt_ready;
  logic               w_push;
  logic               w_pop;
  logic [c_tag_w-1:0] w_head;
  logic [c_tag_w-1:0] w_push_tag;

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  assign w_hit   = ({1'b0, i_req_cfu} < c_n_cfus);
  assign w_head  = r_tags[r_rd_ptr];

  // Decoded target select; all-zero for an out-of-range index.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_CFUS; i++) begin
      w_sel[i] = (i_req_cfu == CFU_ID_W'(i));
    end
  end

  assign w_tgt_ready   = |(w_sel & i_t_req_ready);
  assign o_req_ready   = !w_full && (!w_hit || w_tgt_ready);
  // Targets are never offered a request while the mux is held in reset.
  assign o_t_req_valid = (i_req_valid && rst_n && !w_full) ? w_sel : '0;
  assign o_t_req_func  = i_req_func;
  assign o_t_req_data0 = i_req_data0;
  assign o_t_req_data1 = i_req_data1;

  assign w_push     = i_req_valid && o_req_ready;
  assign w_push_tag = w_hit ? c_tag_w'(i_req_cfu) : c_tag_err;

  always_comb begin
    o_resp_valid   = 1'b0;
    o_resp_status  = '0;
    o_resp_data    = '0;
    o_t_resp_ready = '0;
    if (!w_empty) begin
      if (w_head == c_tag_err) begin
        o_resp_valid  = 1'b1;
        o_resp_status = CFU_ERROR_CFU;
      end else begin
        for (int i = 0; i < N_CFUS; i++) begin
          if (w_head == c_tag_w'(i)) begin
            o_resp_valid      = i_t_resp_valid[i];
            o_resp_status     = i_t_resp_status[i*CFU_STATUS_W +: CFU_STATUS_W];
            o_resp_data       = i_t_resp_data[i*DATA_W +: DATA_W];
            o_t_resp_ready[i] = i_resp_ready;
          end
        end
      end
    end
  end

  assign w_pop = o_resp_valid && i_resp_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tags[r_wr_ptr] <= w_push_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muxn_cxu.sv
`default_nettype none
// ============================================================================
// Module   : tb_muxn_cxu
// Purpose  : Self-checking bench for muxn_cxu with latency-modelled targets.
// Revision : 1.0
// ============================================================================
module tb_muxn_cxu;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int SW = 3;
  localparam logic [SW-1:0] ERR = 3'd1;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_cfu;
  logic [9:0]      req_func;
  logic [31:0]     req_data0;
  logic [31:0]     req_data1;
  logic            resp_valid;
  logic            resp_ready;
  logic [SW-1:0]   resp_status;
  logic [31:0]     resp_data;
  logic [N-1:0]    t_req_valid;
  logic [N-1:0]    t_req_ready;
  logic [9:0]      t_req_func;
  logic [31:0]     t_req_data0;
  logic [31:0]     t_req_data1;
  logic [N-1:0]    t_resp_valid;
  logic [N-1:0]    t_resp_ready;
  logic [N*SW-1:0] t_resp_status;
  logic [N*32-1:0] t_resp_data;

  int checks = 0;
  int errors = 0;

  muxn_cxu #(
    .N_CFUS(N), .CFU_ID_W(4), .FUNC_ID_W(10), .DATA_W(32),
    .MAX_INFLIGHT(D), .CFU_STATUS_W(SW), .CFU_ERROR_CFU(ERR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_cfu(req_cfu),
    .i_req_func(req_func), .i_req_data0(req_data0), .i_req_data1(req_data1),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_status(resp_status), .o_resp_data(resp_data),
    .o_t_req_valid(t_req_valid), .i_t_req_ready(t_req_ready),
    .o_t_req_func(t_req_func), .o_t_req_data0(t_req_data0), .o_t_req_data1(t_req_data1),
    .i_t_resp_valid(t_resp_valid), .o_t_resp_ready(t_resp_ready),
    .i_t_resp_status(t_resp_status), .i_t_resp_data(t_resp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Target models: each computes d0*d1+func, answering in order after lat[i] cycles.
  logic [31:0]  tq_d [N][$];
  int           tq_t [N][$];
  int           lat  [N];
  bit           rnd_rdy;
  int           cyc;
  logic [N-1:0] tv;
  logic [N*32-1:0] tdd;

  assign t_resp_status = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        tq_d[i].delete();
        tq_t[i].delete();
      end
      t_resp_valid <= '0;
      t_resp_data  <= '0;
      t_req_ready  <= '1;
      cyc = 0;
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < N; i++) begin
        if (t_resp_valid[i] && t_resp_ready[i]) begin
          void'(tq_d[i].pop_front());
          void'(tq_t[i].pop_front());
        end
        if (t_req_valid[i] && t_req_ready[i]) begin
          tq_d[i].push_back(t_req_data0 * t_req_data1 + 32'(t_req_func));
          tq_t[i].push_back(cyc + lat[i] - 1);
        end
      end
      tv  = '0;
      tdd = '0;
      for (int i = 0; i < N; i++) begin
        if (tq_d[i].size() > 0) begin
          tdd[i*32 +: 32] = tq_d[i][0];
          tv[i] = (tq_t[i][0] <= cyc);
        end
      end
      t_resp_valid <= tv;
      t_resp_data  <= tdd;
      t_req_ready  <= rnd_rdy ? 4'($urandom) : '1;
    end
  end

  // Reference: every accepted request yields exactly one response, in acceptance order.
  logic [SW+31:0] exp_q [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (resp_valid && resp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (req_valid && req_ready)
        exp_q.push_back((req_cfu < 4'(N)) ? {3'b000, req_data0 * req_data1 + 32'(req_func)}
                                          : {ERR, 32'd0});
    end
  end

  task automatic run_cycle(input bit v, input logic [3:0] cfu, input logic [9:0] f,
                           input logic [31:0] a, input logic [31:0] b, input bit rr);
    @(negedge clk);
    req_valid  = v;
    req_cfu    = cfu;
    req_func   = f;
    req_data0  = a;
    req_data1  = b;
    resp_ready = rr;
    #1;
  endtask

  task automatic test_reset;
    logic [SW+31:0] e;
    int k;
    rst_n = 1'b0;
    rnd_rdy = 1'b0;
    for (int i = 0; i < N; i++) lat[i] = 1;
    run_cycle(1'b1, 4'd2, 10'd0, 32'd1, 32'd1, 1'b1);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (t_req_valid !== 4'b0000) begin errors++; $display("FAIL reset_t_req_valid: got %b want 0000", t_req_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    run_cycle(1'b0, 4'd0, 10'd0, 32'd0, 32'd0, 1'b1);
    rst_n = 1'b1;
    run_cycle(1'b1, 4'd2, 10'd0, 32'd7, 32'd8, 1'b1);
    checks++; if (t_req_valid !== 4'b0100) begin errors++; $display("FAIL post_reset_t_req_valid: got %b want 0100", t_req_valid); end
    k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      run_cycle(1'b0, 4'd0, 10'd0, 32'd0, 32'd0, 1'b1);
      if (resp_valid && resp_ready) begin
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        checks++;
        if (exp_q.size() == 0 || {resp_status, resp_data} !== e) begin
          errors++; $display("FAIL reset_resp: got %h/%h want %h", resp_status, resp_data, e);
        end
      end
      k++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reset_drain: %0d outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_order;
    int n;
    bit stalled;
    logic [31:0] want;
    lat[0] = 5; lat[1] = 1;
    run_cycle(1'b1, 4'd0, 10'd0, 32'd3, 32'd4, 1'b1);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL order_accept_a: got %b want 1", req_ready); end
    run_cycle(1'b1, 4'd1, 10'd0, 32'd5, 32'd6, 1'b1);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL order_accept_b: got %b want 1", req_ready); end
    n = 0;
    stalled = 1'b0;
    for (int k = 0; k < 30 && n < 2; k++) begin
      run_cycle(1'b0, 4'd0, 10'd0, 32'd0, 32'd0, 1'b1);
      if (t_resp_valid[1] && n == 0) begin
        stalled = 1'b1;
        checks++;
        if (t_resp_ready[1] !== 1'b0) begin errors++; $display("FAIL order_stall: t_resp_ready[1]=%b want 0", t_resp_ready[1]); end
      end
      if (resp_valid && resp_ready) begin
        want = (n == 0) ? 32'd12 : 32'd30;
        checks++;
        if (resp_data !== want || resp_status !== 3'd0) begin
          errors++; $display("FAIL order_resp%0d: got %0d/%0d want 0/%0d", n, resp_status, resp_data, want);
        end
        n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL order_count: got %0d responses want 2", n); end
    checks++; if (!stalled) begin errors++; $display("FAIL order_stall_seen: got 0 want 1"); end
    run_cycle(1'b0, 4'd0, 10'd0, 32'd0, 32'd0, 1'b1);
    lat[0] = 1;
  endtask

  task automatic test_bad_index;
    run_cycle(1'b1, 4'd7, 10'd5, 32'd9, 32'd9, 1'b1);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bad_accept: got %b want 1", req_ready); end
    checks++; if (t_req_valid !== 4'b0000) begin errors++; $display("FAIL bad_t_req_valid: got %b want 0000", t_req_valid); end
    run_cycle(1'b0, 4'd0, 10'd0, 32'd0, 32'd0, 1'b1);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bad_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_status !== ERR || resp_data !== 32'd0) begin
      errors++; $display("FAIL bad_resp: got %0d/%0d want %0d/0", resp_status, resp_data, ERR);
    end
    checks++; if (t_resp_ready !== 4'b0000) begin errors++; $display("FAIL bad_t_resp_ready: got %b want 0000", t_resp_ready); end
    run_cycle(1'b0, 4'd0, 10'd0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic test_full;
    logic [SW+31:0] e;
    int k;
    int n;
    for (int i = 0; i < D; i++) begin
      run_cycle(1'b1, 4'(i % N), 10'(i), 32'(i + 1), 32'(i + 2), 1'b0);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_accept%0d: got %b want 1", i, req_ready); end
    end
    run_cycle(1'b1, 4'd1, 10'd3, 32'd10, 32'd11, 1'b0);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_block: got %b want 0", req_ready); end
    checks++; if (t_req_valid !== 4'b0000) begin errors++; $display("FAIL full_t_req_valid: got %b want 0000", t_req_valid); end
    run_cycle(1'b1, 4'd1, 10'd3, 32'd10, 32'd11, 1'b1);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_pushpop_block: got %b want 0", req_ready); end
    e = (exp_q.size() > 0) ? exp_q[0] : '0;
    checks++; if (resp_valid !== 1'b1 || {resp_status, resp_data} !== e) begin
      errors++; $display("FAIL full_pop: got v=%b %h/%h want v=1 %h", resp_valid, resp_status, resp_data, e);
    end
    run_cycle(1'b1, 4'd1, 10'd3, 32'd10, 32'd11, 1'b0);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop: got %b want 1", req_ready); end
    run_cycle(1'b0, 4'd0, 10'd0, 32'd0, 32'd0, 1'b0);
    checks++; if (req_ready !== 1'b0 || exp_q.size() != D) begin
      errors++; $display("FAIL full_refill: req_ready=%b outstanding=%0d want 0/%0d", req_ready, exp_q.size(), D);
    end
    k = 0; n = 0;
    while (exp_q.size() > 0 && k < 100) begin
      run_cycle(1'b0, 4'd0, 10'd0, 32'd0, 32'd0, 1'b1);
      if (resp_valid && resp_ready) begin
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        checks++;
        if (exp_q.size() == 0 || {resp_status, resp_data} !== e) begin
          errors++; $display("FAIL full_drain_resp: got %h/%h want %h", resp_status, resp_data, e);
        end
        n++;
      end
      k++;
    end
    checks++; if (n != D) begin errors++; $display("FAIL full_drain_count: got %0d want %0d", n, D); end
  endtask

  task automatic test_random;
    logic [SW+31:0] e;
    logic [3:0]  cfu;
    logic [9:0]  f;
    logic [31:0] a, b;
    logic [N-1:0] exp_tv;
    bit v, rr, hit, exp_rdy, accepted;
    int k;
    for (int i = 0; i < N; i++) lat[i] = $urandom_range(1, 4);
    rnd_rdy = 1'b1;
    for (int r = 0; r < 100; r++) begin
      cfu = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) cfu = 4'd15;
      f = 10'($urandom);
      a = $urandom;
      b = $urandom;
      hit = (cfu < 4'(N));
      accepted = 1'b0;
      k = 0;
      while (!accepted && k < 100) begin
        v  = ($urandom_range(0, 3) != 0);
        rr = ($urandom_range(0, 2) != 0);
        run_cycle(v, cfu, f, a, b, rr);
        exp_rdy = (exp_q.size() < D) && (!hit || t_req_ready[cfu[1:0]]);
        exp_tv  = (v && hit && exp_q.size() < D) ? (4'(1) << cfu[1:0]) : 4'b0000;
        checks++;
        if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_req_ready: got %b want %b", req_ready, exp_rdy); end
        checks++;
        if (t_req_valid !== exp_tv) begin errors++; $display("FAIL rand_t_req_valid: got %b want %b", t_req_valid, exp_tv); end
        if (resp_valid && resp_ready) begin
          e = (exp_q.size() > 0) ? exp_q[0] : '0;
          checks++;
          if (exp_q.size() == 0 || {resp_status, resp_data} !== e) begin
            errors++; $display("FAIL rand_resp: got %h/%h want %h", resp_status, resp_data, e);
          end
        end
        accepted = v && req_ready;
        k++;
      end
      if (!accepted) begin
        checks++; errors++; $display("FAIL rand_accept_timeout: request %0d got 0 want 1", r);
      end
    end
    rnd_rdy = 1'b0;
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      run_cycle(1'b0, 4'd0, 10'd0, 32'd0, 32'd0, 1'b1);
      if (resp_valid && resp_ready) begin
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        checks++;
        if (exp_q.size() == 0 || {resp_status, resp_data} !== e) begin
          errors++; $display("FAIL rand_drain_resp: got %h/%h want %h", resp_status, resp_data, e);
        end
      end
      k++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: %0d outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_wrap;
    logic [SW+31:0] e;
    logic [3:0] cfu;
    bit accepted;
    int k;
    int n;
    for (int i = 0; i < N; i++) lat[i] = 1;
    n = 0;
    for (int r = 0; r < 3 * D; r++) begin
      cfu = (r % 2 == 0) ? 4'd0 : 4'd3;
      accepted = 1'b0;
      k = 0;
      while (!accepted && k < 50) begin
        run_cycle(1'b1, cfu, 10'(r), 32'(r + 100), 32'(r * 3 + 1), 1'b1);
        if (resp_valid && resp_ready) begin
          e = (exp_q.size() > 0) ? exp_q[0] : '0;
          checks++;
          if (exp_q.size() == 0 || {resp_status, resp_data} !== e) begin
            errors++; $display("FAIL wrap_resp: got %h/%h want %h", resp_status, resp_data, e);
          end
          n++;
        end
        accepted = req_ready;
        k++;
      end
      if (!accepted) begin
        checks++; errors++; $display("FAIL wrap_accept_timeout: request %0d got 0 want 1", r);
      end
    end
    k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      run_cycle(1'b0, 4'd0, 10'd0, 32'd0, 32'd0, 1'b1);
      if (resp_valid && resp_ready) begin
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        checks++;
        if (exp_q.size() == 0 || {resp_status, resp_data} !== e) begin
          errors++; $display("FAIL wrap_drain_resp: got %h/%h want %h", resp_status, resp_data, e);
        end
        n++;
      end
      k++;
    end
    checks++; if (n != 3 * D) begin errors++; $display("FAIL wrap_count: got %0d want %0d", n, 3 * D); end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_cfu    = '0;
    req_func   = '0;
    req_data0  = '0;
    req_data1  = '0;
    resp_ready = 1'b0;
    rnd_rdy    = 1'b0;
    for (int i = 0; i < N; i++) lat[i] = 1;
    test_reset();
    test_order();
    test_bad_index();
    test_full();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
